// File: rtl/stack_ctrl_if.sv
// Bundle of request, RAM-side and status signals for the 4-deep stack controller.
// The slave side is the controller itself; the master side is its user plus RAM.
interface stack_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              push_i;
  logic              pop_i;
  logic [DATA_W-1:0] data_i;
  logic [1:0]        ram_addr_o;
  logic              ram_we_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic [2:0]        count_o;
  logic              full_o;
  logic              empty_o;
  logic              busy_o;
  logic              err_o;

  modport slave (
    input  push_i, pop_i, data_i, ram_rdata_i,
    output ram_addr_o, ram_we_o, ram_wdata_o, data_o, valid_o,
           count_o, full_o, empty_o, busy_o, err_o
  );

  modport master (
    output push_i, pop_i, data_i, ram_rdata_i,
    input  ram_addr_o, ram_we_o, ram_wdata_o, data_o, valid_o,
           count_o, full_o, empty_o, busy_o, err_o
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO controller over an external 4-row RAM with a one-cycle registered read port.
// Push takes one busy cycle, pop takes two (address, then data capture).
module stack_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  stack_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_POP_ADDR,
    S_POP_DATA
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              err_q,   err_d;

  logic              full, empty;
  logic [2:0]        top_idx;

  assign full    = (count_q == 3'd4);
  assign empty   = (count_q == 3'd0);
  assign top_idx = count_q - 3'd1;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.push_i && bus.pop_i) begin
          err_d = 1'b1;
        end else if (bus.push_i) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wdata_d = bus.data_i;
            state_d = S_PUSH;
          end
        end else if (bus.pop_i) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            state_d = S_POP_ADDR;
          end
        end
      end
      S_PUSH: begin
        count_d = count_q + 3'd1;
        state_d = S_IDLE;
      end
      S_POP_ADDR: begin
        state_d = S_POP_DATA;
      end
      S_POP_DATA: begin
        // RAM read data now reflects the address presented during S_POP_ADDR.
        data_d  = bus.ram_rdata_i;
        count_d = count_q - 3'd1;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= 3'd0;
      wdata_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Outside a push the address points at the current top of stack (row 0 when empty).
  always_comb begin
    bus.ram_we_o    = (state_q == S_PUSH);
    bus.ram_wdata_o = wdata_q;
    if (state_q == S_PUSH) begin
      bus.ram_addr_o = count_q[1:0];
    end else if (empty) begin
      bus.ram_addr_o = 2'd0;
    end else begin
      bus.ram_addr_o = top_idx[1:0];
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;
  assign bus.count_o = count_q;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: a queue-based LIFO model, a 4-row RAM with
// registered read, and a 2-to-4 row decoder driven from the RAM-side outputs.
module tb_stack_ctrl;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_W(DATA_W)) bus ();

  stack_ctrl #(.DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // External RAM: contents survive reset, read data registered one cycle.
  logic [DATA_W-1:0] mem [4];
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  // Downstream 2-to-4 row decoder.
  logic [3:0] dec;
  assign dec = bus.ram_we_o ? (4'b0001 << bus.ram_addr_o) : 4'b0000;

  logic [DATA_W-1:0] model_q [$];
  int vectors    = 0;
  int miscompares = 0;
  int we_pulses = 0, valid_pulses = 0, err_pulses = 0, dec_cycles = 0;
  int exp_we = 0, exp_valid = 0, exp_err = 0;

  always @(negedge clk) begin
    if (bus.ram_we_o) we_pulses++;
    if (bus.valid_o)  valid_pulses++;
    if (bus.err_o)    err_pulses++;
    if (dec != 4'b0000) dec_cycles++;
  end

  // Caller is positioned at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic op_push(input logic [DATA_W-1:0] d);
    int c = model_q.size();
    bus.push_i = 1'b1;
    bus.data_i = d;
    @(negedge clk);
    bus.push_i = 1'b0;
    bus.data_i = DATA_W'($urandom);
    if (c == 4) begin
      exp_err++;
      vectors++; if (bus.err_o !== 1'b1) begin miscompares++; $display("FAIL push_full_err: got %b want 1", bus.err_o); end
      vectors++; if (bus.count_o !== 3'd4) begin miscompares++; $display("FAIL push_full_count: got %0d want 4", bus.count_o); end
      vectors++; if (bus.ram_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL push_full_quiet: we=%b busy=%b want 0 0", bus.ram_we_o, bus.busy_o); end
    end else begin
      exp_we++;
      vectors++; if (bus.ram_we_o !== 1'b1 || bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL push_we: we=%b busy=%b want 1 1", bus.ram_we_o, bus.busy_o); end
      vectors++; if (bus.ram_addr_o !== 2'(c)) begin miscompares++; $display("FAIL push_addr: got %0d want %0d", bus.ram_addr_o, c); end
      vectors++; if (bus.ram_wdata_o !== d) begin miscompares++; $display("FAIL push_wdata: got %h want %h", bus.ram_wdata_o, d); end
      vectors++; if ($countones(dec) != 1 || dec[c] !== 1'b1) begin miscompares++; $display("FAIL push_decoder: got %b want row %0d only", dec, c); end
      model_q.push_back(d);
      @(negedge clk);
      vectors++; if (bus.ram_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL push_done: we=%b busy=%b want 0 0", bus.ram_we_o, bus.busy_o); end
      vectors++; if (bus.count_o !== 3'(c + 1) || bus.full_o !== (c == 3) || bus.empty_o !== 1'b0) begin
        miscompares++; $display("FAIL push_count: count=%0d full=%b empty=%b want %0d %b 0", bus.count_o, bus.full_o, bus.empty_o, c + 1, c == 3);
      end
      vectors++; if (bus.ram_addr_o !== 2'(c)) begin miscompares++; $display("FAIL push_top_addr: got %0d want %0d", bus.ram_addr_o, c); end
    end
  endtask

  // inject=1 raises push_i during the address phase, which must be ignored.
  task automatic op_pop(input bit inject);
    int c = model_q.size();
    logic [DATA_W-1:0] exp_d;
    bus.pop_i = 1'b1;
    @(negedge clk);
    bus.pop_i = 1'b0;
    if (c == 0) begin
      exp_err++;
      vectors++; if (bus.err_o !== 1'b1) begin miscompares++; $display("FAIL pop_empty_err: got %b want 1", bus.err_o); end
      vectors++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.ram_we_o !== 1'b0) begin
        miscompares++; $display("FAIL pop_empty_state: count=%0d empty=%b busy=%b we=%b want 0 1 0 0", bus.count_o, bus.empty_o, bus.busy_o, bus.ram_we_o);
      end
    end else begin
      vectors++; if (bus.busy_o !== 1'b1 || bus.ram_we_o !== 1'b0 || bus.ram_addr_o !== 2'(c - 1)) begin
        miscompares++; $display("FAIL pop_addr: busy=%b we=%b addr=%0d want 1 0 %0d", bus.busy_o, bus.ram_we_o, bus.ram_addr_o, c - 1);
      end
      bus.push_i = inject;
      bus.data_i = DATA_W'($urandom);
      @(negedge clk);
      bus.push_i = 1'b0;
      vectors++; if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.err_o !== 1'b0) begin
        miscompares++; $display("FAIL pop_data_phase: busy=%b valid=%b err=%b want 1 0 0", bus.busy_o, bus.valid_o, bus.err_o);
      end
      @(negedge clk);
      exp_d = model_q.pop_back();
      exp_valid++;
      vectors++; if (bus.valid_o !== 1'b1 || bus.data_o !== exp_d) begin
        miscompares++; $display("FAIL pop_result: valid=%b data=%h want 1 %h", bus.valid_o, bus.data_o, exp_d);
      end
      vectors++; if (bus.busy_o !== 1'b0 || bus.count_o !== 3'(c - 1) || bus.empty_o !== (c == 1) || bus.full_o !== 1'b0) begin
        miscompares++; $display("FAIL pop_count: busy=%b count=%0d empty=%b full=%b want 0 %0d %b 0", bus.busy_o, bus.count_o, bus.empty_o, bus.full_o, c - 1, c == 1);
      end
    end
  endtask

  task automatic op_both();
    int c = model_q.size();
    bus.push_i = 1'b1;
    bus.pop_i  = 1'b1;
    @(negedge clk);
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    exp_err++;
    vectors++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.count_o !== 3'(c)) begin
      miscompares++; $display("FAIL both_err: err=%b busy=%b count=%0d want 1 0 %0d", bus.err_o, bus.busy_o, bus.count_o, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (bus.count_o !== 3'd0 || bus.empty_o !== 1'b1 || bus.full_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_status: count=%0d empty=%b full=%b busy=%b want 0 1 0 0", bus.count_o, bus.empty_o, bus.full_o, bus.busy_o);
    end
    vectors++; if (bus.valid_o !== 1'b0 || bus.err_o !== 1'b0 || bus.ram_we_o !== 1'b0 || bus.ram_addr_o !== 2'd0 || bus.data_o !== '0) begin
      miscompares++; $display("FAIL reset_outputs: valid=%b err=%b we=%b addr=%0d data=%h want 0 0 0 0 00", bus.valid_o, bus.err_o, bus.ram_we_o, bus.ram_addr_o, bus.data_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    op_push(8'h11); op_push(8'h22); op_push(8'h33); op_push(8'h44);
    vectors++; if (bus.count_o !== 3'd4 || bus.full_o !== 1'b1) begin
      miscompares++; $display("FAIL fill_full: count=%0d full=%b want 4 1", bus.count_o, bus.full_o);
    end
    repeat (4) op_pop(1'b0);
    vectors++; if (bus.data_o !== 8'h11 || bus.empty_o !== 1'b1) begin
      miscompares++; $display("FAIL drain_last: data=%h empty=%b want 11 1", bus.data_o, bus.empty_o);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) op_push(DATA_W'($urandom));
    op_push(8'hEE);
    repeat (4) op_pop(1'b0);
    op_pop(1'b0);
  endtask

  task automatic test_both_and_ignored();
    op_push(8'h5A); op_push(8'hA5);
    op_both();
    op_pop(1'b1);
    vectors++; if (bus.count_o !== 3'd1) begin miscompares++; $display("FAIL ignored_push_count: got %0d want 1", bus.count_o); end
    op_pop(1'b0);
  endtask

  task automatic test_reset_abort();
    op_push(8'hA5); op_push(8'h5A); op_push(8'hC3);
    op_pop(1'b0);
    bus.pop_i = 1'b1;
    @(negedge clk);
    bus.pop_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    vectors++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.busy_o !== 1'b0 || bus.empty_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_abort: count=%0d valid=%b data=%h busy=%b empty=%b want 0 0 00 0 1", bus.count_o, bus.valid_o, bus.data_o, bus.busy_o, bus.empty_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int r = int'($urandom_range(0, 9));
      if (r <= 3)      op_push(DATA_W'($urandom));
      else if (r <= 6) op_pop(1'($urandom));
      else if (r == 7) op_both();
      else begin
        @(negedge clk);
        vectors++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0 || bus.count_o !== 3'(model_q.size())) begin
          miscompares++; $display("FAIL idle_state: busy=%b err=%b count=%0d want 0 0 %0d", bus.busy_o, bus.err_o, bus.count_o, model_q.size());
        end
      end
    end
  endtask

  initial begin
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    bus.data_i = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_errors();
    test_both_and_ignored();
    test_reset_abort();
    test_random();
    repeat (2) @(negedge clk);
    vectors++; if (we_pulses != exp_we || dec_cycles != exp_we) begin
      miscompares++; $display("FAIL write_pulses: we=%0d decoder=%0d want %0d", we_pulses, dec_cycles, exp_we);
    end
    vectors++; if (valid_pulses != exp_valid) begin
      miscompares++; $display("FAIL valid_pulses: got %0d want %0d", valid_pulses, exp_valid);
    end
    vectors++; if (err_pulses != exp_err) begin
      miscompares++; $display("FAIL err_pulses: got %0d want %0d", err_pulses, exp_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
